// File: rtl/pipeline_skid_buffer.sv
// Two-entry skid buffer. It registers every output and decouples in_ready from out_ready,
// so the buffer can break a combinational ready path between pipeline stages.
module pipeline_skid_buffer #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  input  logic         out_ready,
  input  logic         flush,
  output logic [1:0]   count,
  output logic [1:0]   dbg_state
);

  // Handshake: a push happens on an edge where in_valid && in_ready; a pop happens on an
  // edge where out_valid && out_ready. Neither side may take back a word it is presenting.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_BUSY  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t         r_state;
  logic [N-1:0]   r_main;
  logic [N-1:0]   r_skid;
  logic           r_in_ready;
  logic           r_out_valid;
  logic [1:0]     r_count;

  logic           w_push;
  logic           w_pop;
  state_t         w_next_state;
  logic [1:0]     w_next_count;

  assign w_push = in_valid & r_in_ready;
  assign w_pop  = r_out_valid & out_ready;

  always_comb begin
    w_next_state = S_EMPTY;
    case (r_state)
      S_EMPTY: w_next_state = w_push ? S_BUSY : S_EMPTY;
      S_BUSY: begin
        if (w_push && !w_pop)      w_next_state = S_FULL;
        else if (!w_push && w_pop) w_next_state = S_EMPTY;
        else                       w_next_state = S_BUSY;
      end
      S_FULL:  w_next_state = w_pop ? S_BUSY : S_FULL;
      default: w_next_state = S_EMPTY;
    endcase
  end

  always_comb begin
    w_next_count = 2'd0;
    case (w_next_state)
      S_BUSY:  w_next_count = 2'd1;
      S_FULL:  w_next_count = 2'd2;
      default: w_next_count = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_count     <= 2'd0;
    end else if (flush) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_count     <= 2'd0;
    end else begin
      r_state     <= w_next_state;
      // Ready and valid come from the next state, so out_ready never reaches in_ready combinationally.
      r_in_ready  <= (w_next_state != S_FULL);
      r_out_valid <= (w_next_state != S_EMPTY);
      r_count     <= w_next_count;
      case (r_state)
        S_EMPTY: if (w_push) r_main <= in_data;
        S_BUSY: begin
          if (w_push && w_pop)       r_main <= in_data;
          else if (w_push && !w_pop) r_skid <= in_data;
        end
        S_FULL:  if (w_pop) r_main <= r_skid;
        default: ;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;
  assign count     = r_count;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_pipeline_skid_buffer.sv
// Bench for pipeline_skid_buffer. It applies directed vector tables and hand sequences,
// then random traffic scored against a queue-based reference model.
module tb_pipeline_skid_buffer;

  localparam int N = 32;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic [N-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [N-1:0] out_data;
  logic         out_ready;
  logic         flush;
  logic [1:0]   count;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_skid_buffer #(.N(N)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .flush(flush), .count(count), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: the held words in order, plus whether the buffer accepts this cycle
  logic [N-1:0] exp_q[$];
  logic         m_rdy;

  task automatic m_reset();
    exp_q.delete();
    m_rdy = 1'b0;
  endtask

  task automatic model_edge();
    logic do_push, do_pop;
    if (!reset) begin
      m_reset();
    end else if (flush) begin
      exp_q.delete();
      m_rdy = 1'b1;
    end else begin
      do_push = in_valid && m_rdy;
      do_pop  = (exp_q.size() > 0) && out_ready;
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(in_data);
      m_rdy = (exp_q.size() < 2);
    end
  endtask

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, " out_valid"}, N'(out_valid), N'(exp_q.size() > 0));
    check({tag, " in_ready"}, N'(in_ready), N'(m_rdy));
    check({tag, " count"}, N'(count), N'(exp_q.size()));
    if (exp_q.size() > 0) check({tag, " out_data"}, out_data, exp_q[0]);
  endtask

  // driver: inputs change at negedge, DUT samples at posedge, outputs checked at next negedge
  task automatic step(input logic iv, input logic [N-1:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  typedef struct {
    logic         iv;
    logic [N-1:0] d;
    logic         ordy;
    logic         fl;
    logic         e_valid;
    logic         e_ready;
    logic [1:0]   e_count;
    logic [N-1:0] e_data;
  } vec_t;

  vec_t vecs[15];

  initial begin
    // iv, data, out_ready, flush -> valid, ready, count, data
    vecs[0]  = '{1'b1, 32'h55555555, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0};
    vecs[1]  = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0};
    vecs[3]  = '{1'b1, 32'h11111111, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 32'h11111111};
    vecs[4]  = '{1'b1, 32'h22222222, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 32'h11111111};
    vecs[5]  = '{1'b1, 32'h33333333, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 32'h11111111};
    vecs[6]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 32'h22222222};
    vecs[7]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0};
    vecs[8]  = '{1'b1, 32'h44444444, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 32'h44444444};
    vecs[9]  = '{1'b1, 32'h55555555, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 32'h44444444};
    vecs[10] = '{1'b1, 32'hAAAAAAAA, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0};
    vecs[11] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0};
    vecs[12] = '{1'b1, 32'h66666666, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 32'h66666666};
    vecs[13] = '{1'b1, 32'hAAAAAAAA, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0};
    vecs[14] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0};

    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    m_reset();
    #2 reset = 1'b0;
    #5;
    check("reset out_valid", N'(out_valid), '0);
    check("reset in_ready", N'(in_ready), '0);
    check("reset count", N'(count), '0);
    check("reset out_data", out_data, '0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    check("release in_ready", N'(in_ready), '0);

    // directed table
    for (int i = 0; i < 15; i++) begin
      step(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl);
      check($sformatf("vec%0d out_valid", i), N'(out_valid), N'(vecs[i].e_valid));
      check($sformatf("vec%0d in_ready", i), N'(in_ready), N'(vecs[i].e_ready));
      check($sformatf("vec%0d count", i), N'(count), N'(vecs[i].e_count));
      if (vecs[i].e_valid) check($sformatf("vec%0d out_data", i), out_data, vecs[i].e_data);
    end

    // streaming at full throughput
    for (int i = 0; i < 16; i++) begin
      step(1'b1, N'(i), 1'b1, 1'b0);
      check($sformatf("stream%0d out_data", i), out_data, N'(i));
      check($sformatf("stream%0d out_valid", i), N'(out_valid), N'(1));
      check($sformatf("stream%0d count", i), N'(count), N'(1));
      check($sformatf("stream%0d in_ready", i), N'(in_ready), N'(1));
    end
    step(1'b0, '0, 1'b1, 1'b0);
    check("stream end count", N'(count), '0);

    // asynchronous reset while full
    step(1'b1, 32'hB1B1B1B1, 1'b0, 1'b0);
    step(1'b1, 32'hB2B2B2B2, 1'b0, 1'b0);
    check_model("prefill");
    #2 reset = 1'b0;
    #1;
    check("async out_valid", N'(out_valid), '0);
    check("async in_ready", N'(in_ready), '0);
    check("async count", N'(count), '0);
    check("async out_data", out_data, '0);
    m_reset();
    @(negedge clk);
    reset = 1'b1;
    check("async release in_ready", N'(in_ready), '0);
    step(1'b1, 32'h77777777, 1'b1, 1'b0);
    check_model("first edge");
    check("first edge count", N'(count), '0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("post reset out_valid", N'(out_valid), '0);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), N'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 19) == 0));
      check_model($sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
